// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: walks an active-low row strobe, samples the synchronized columns once
// per row, debounces whole-matrix frames and shifts each accepted key into a 16-bit entry register.
module keypad_scanner #(
    parameter int PERIOD   = 50_000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:3]  col,
    output logic [0:3]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] value
);

    localparam int             DW         = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(PERIOD - 1);
    localparam logic [3:0]     DEB        = 4'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_t;
    typedef enum logic [1:0] {F_NONE, F_SINGLE, F_MULTI} frame_t;

    function automatic logic [0:3] row_drive(input logic [1:0] r);
        row_drive    = 4'b1111;
        row_drive[r] = 1'b0;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    logic [0:3]    col_s1, col_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    ridx;
    logic          sample, frame_end;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_s1 <= 4'b1111;
            col_s2 <= 4'b1111;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
        end
    end

    assign sample    = (dwell == DWELL_LAST);
    assign frame_end = sample && (ridx == 2'd3);

    always_ff @(posedge clock) begin
        if (reset) begin
            dwell <= '0;
            ridx  <= 2'd0;
            row   <= 4'b0111;
        end else if (sample) begin
            dwell <= '0;
            ridx  <= ridx + 2'd1;
            row   <= row_drive(ridx + 2'd1);
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Per-sample hit count saturates at 2, which is all a frame needs to tell SINGLE from MULTI.
    logic [1:0] hits, acc_hits, base_hits, tot_hits;
    logic [3:0] hit_key, acc_key, tot_key;
    logic [2:0] hit_sum;
    frame_t     frame;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        hits    = 2'd0;
        hit_key = 4'h0;
        for (int c = 0; c < 4; c++) begin
            if (!col_s2[c]) begin
                if (hits != 2'd2) hits = hits + 2'd1;
                hit_key = key_map(ridx, 2'(c));
            end
        end
        base_hits = (ridx == 2'd0) ? 2'd0 : acc_hits;
        hit_sum   = {1'b0, base_hits} + {1'b0, hits};
        tot_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        tot_key   = (base_hits == 2'd0) ? hit_key : acc_key;
        case (tot_hits)
            2'd0:    frame = F_NONE;
            2'd1:    frame = F_SINGLE;
            default: frame = F_MULTI;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_hits <= 2'd0;
            acc_key  <= 4'h0;
        end else if (sample) begin
            acc_hits <= tot_hits;
            acc_key  <= tot_key;
        end
    end

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n, cnt_inc, cand, cand_n;
    logic       accept;

    assign cnt_inc = cnt + 4'd1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        accept  = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE: begin
                    if (frame == F_SINGLE) begin
                        cand_n = tot_key;
                        cnt_n  = 4'd1;
                        if (DEB == 4'd1) accept = 1'b1;
                        else             state_n = ARMING;
                    end
                end
                ARMING: begin
                    if (frame != F_SINGLE) begin
                        state_n = IDLE;
                    end else if (tot_key == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB) accept = 1'b1;
                    end else begin
                        cand_n = tot_key;
                        cnt_n  = 4'd1;
                    end
                end
                PRESSED: begin
                    if (frame == F_NONE) begin
                        cnt_n   = 4'd1;
                        state_n = (DEB == 4'd1) ? IDLE : RELEASING;
                    end
                end
                RELEASING: begin
                    if (frame == F_NONE) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB) state_n = IDLE;
                    end else if (frame == F_SINGLE && tot_key == cand) begin
                        state_n = PRESSED;
                    end else begin
                        cnt_n = 4'd0;
                    end
                end
            endcase
            if (accept) state_n = PRESSED;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cand      <= 4'h0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            value     <= 16'h0000;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_valid <= accept;
            if (accept) begin
                key_code <= cand_n;
                value    <= {value[11:0], cand_n};
            end
        end
    end

    assign key_down = (state == PRESSED) || (state == RELEASING);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives col from row, and a frame-level
// streak model predicts every output cycle by cycle, plus hand-computed literal checkpoints.
module tb_keypad_scanner;

    localparam int P = 4;
    localparam int D = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [0:3]  col;
    logic [0:3]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] value;

    logic [15:0] pressed = 16'h0;   // bit r*4+c = key at row r, column c held

    int checks = 0;
    int errors = 0;

    keypad_scanner #(.PERIOD(P), .DEBOUNCE(D)) dut (
        .clock(clock), .reset(reset), .col(col), .row(row),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .value(value)
    );

    always #5 clock = ~clock;

    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
    end

    function automatic logic [3:0] key_at(input int i);
        case (i)
            0: key_at = 4'h1;  1: key_at = 4'h2;  2: key_at = 4'h3;  3: key_at = 4'hA;
            4: key_at = 4'h4;  5: key_at = 4'h5;  6: key_at = 4'h6;  7: key_at = 4'hB;
            8: key_at = 4'h7;  9: key_at = 4'h8; 10: key_at = 4'h9; 11: key_at = 4'hC;
           12: key_at = 4'hE; 13: key_at = 4'h0; 14: key_at = 4'hF; default: key_at = 4'hD;
        endcase
    endfunction

    function automatic logic [15:0] key_bit(input logic [3:0] k);
        key_bit = 16'h0;
        for (int i = 0; i < 16; i++)
            if (key_at(i) == k) key_bit = 16'h1 << i;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: cycle count since reset gives scan position; frames reduce to streaks.
    int          cyc = 0;
    logic [3:0]  snap [4];
    logic [0:3]  m_row = 4'b0111;
    logic [3:0]  m_code = 4'h0, m_last = 4'h0;
    logic [15:0] m_value = 16'h0;
    logic        m_valid = 1'b0, m_held = 1'b0;
    int          m_streak = 0, m_none = 0;

    task automatic model_frame();
        int total;
        logic [3:0] k;
        total = 0;
        k = 4'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (snap[r][c]) begin
                    total++;
                    k = key_at(r*4+c);
                end
        if (!m_held) begin
            if (total == 1) begin
                m_streak = (m_streak > 0 && k == m_last) ? m_streak + 1 : 1;
                m_last   = k;
            end else begin
                m_streak = 0;
            end
            if (m_streak == D) begin
                m_held   = 1'b1;
                m_none   = 0;
                m_streak = 0;
                m_valid  = 1'b1;
                m_code   = m_last;
                m_value  = {m_value[11:0], m_last};
            end
        end else begin
            m_none = (total == 0) ? m_none + 1 : 0;
            if (m_none == D) begin
                m_held   = 1'b0;
                m_none   = 0;
                m_streak = 0;
            end
        end
    endtask

    initial forever begin
        int dw, rr;
        @(posedge clock);
        if (reset) begin
            cyc = 0; m_value = 16'h0; m_code = 4'h0; m_valid = 1'b0;
            m_held = 1'b0; m_streak = 0; m_none = 0;
        end else begin
            m_valid = 1'b0;
            dw = cyc % P;
            rr = (cyc / P) % 4;
            // Columns pass two sync flops, so the sample at dwell P-1 reflects the keys at dwell 1.
            if (dw == 1) snap[rr] = pressed[rr*4 +: 4];
            if (dw == P - 1 && rr == 3) model_frame();
            cyc++;
        end
        m_row = 4'b1111;
        m_row[(cyc / P) % 4] = 1'b0;
    end

    int   pulses = 0, last_pulse_cyc = -1, kd_fall_cyc = -1;
    logic kd_prev = 1'b0;

    initial forever begin
        @(negedge clock);
        check("row", row, m_row);
        check("key_valid", key_valid, m_valid);
        check("key_down", key_down, m_held);
        check("key_code", key_code, m_code);
        check("value", value, m_value);
        if (key_valid === 1'b1) begin
            pulses++;
            last_pulse_cyc = cyc;
        end
        if (kd_prev && key_down === 1'b0) kd_fall_cyc = cyc;
        kd_prev = (key_down === 1'b1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clock);
    endtask

    task automatic enter(input logic [3:0] k);
        pressed = key_bit(k);
        cycles(48);
        pressed = 16'h0;
        cycles(64);
    endtask

    initial begin
        reset   = 1'b1;
        pressed = key_bit(4'h5);
        cycles(3);
        check("reset row", row, 4'b0111);
        check("reset value", value, 16'h0000);
        check("reset key_valid", key_valid, 1'b0);
        check("reset key_down", key_down, 1'b0);
        reset = 1'b0;

        wait_cyc(3);  check("row c3", row, 4'b0111);
        wait_cyc(4);  check("row c4", row, 4'b1011);
        wait_cyc(8);  check("row c8", row, 4'b1101);
        wait_cyc(12); check("row c12", row, 4'b1110);
        wait_cyc(16); check("row c16 wrap", row, 4'b0111);

        wait_cyc(33);
        check("press5 pulse cycle", last_pulse_cyc, 32);
        check("press5 pulses", pulses, 1);
        check("press5 code", key_code, 4'h5);
        check("press5 value", value, 16'h0005);
        wait_cyc(40);
        pressed = 16'h0;
        wait_cyc(100);
        check("release5 fall cycle", kd_fall_cyc, 80);
        check("release5 pulses", pulses, 1);

        enter(4'h1); enter(4'h2); enter(4'h3); enter(4'hA);
        check("entry value", value, 16'h123A);
        check("entry pulses", pulses, 5);
        enter(4'h4);
        check("entry shift value", value, 16'h23A4);
        check("entry shift pulses", pulses, 6);

        pressed = key_bit(4'h7);
        cycles(10);
        pressed = 16'h0;
        cycles(64);
        check("bounce pulses", pulses, 6);
        check("bounce key_down", key_down, 1'b0);

        pressed = key_bit(4'h8);
        cycles(48);
        check("glitch accept", pulses, 7);
        pressed = 16'h0;
        cycles(10);
        check("glitch key_down held", key_down, 1'b1);
        pressed = key_bit(4'h8);
        cycles(48);
        check("glitch no repulse", pulses, 7);
        pressed = 16'h0;
        cycles(64);

        pressed = key_bit(4'h1) | key_bit(4'h9);
        cycles(48);
        check("multi no pulse", pulses, 7);
        pressed = key_bit(4'h9);
        cycles(48);
        check("multi to single pulse", pulses, 8);
        check("multi to single code", key_code, 4'h9);
        pressed = key_bit(4'h9) | key_bit(4'h0);
        cycles(48);
        check("add key while held", pulses, 8);
        pressed = 16'h0;
        cycles(64);

        reset = 1'b1; cycles(1); reset = 1'b0;
        enter(4'hB); enter(4'h0);
        check("pre-reset value", value, 16'h00B0);
        pressed = key_bit(4'hB);
        cycles(8);
        reset = 1'b1; cycles(1); reset = 1'b0;
        check("mid reset value", value, 16'h0000);
        check("mid reset key_down", key_down, 1'b0);
        cycles(48);
        check("post reset value", value, 16'h000B);
        check("post reset pulses", pulses, 11);
        pressed = 16'h0;
        cycles(64);

        repeat (40) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      pressed = 16'h1 << $urandom_range(0, 15);
            else if (sel < 8) pressed = 16'h0;
            else              pressed = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            cycles(int'($urandom_range(4, 70)));
        end
        pressed = 16'h0;
        cycles(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
